timer_display_monitor: RTL
==========================

Name: timer_display_monitor

Overview:
- Receiving end of the digital timer's six-digit seven-segment bus: captures the segment vector, decodes it back to BCD, and rebuilds elapsed seconds.
- Tracks the sequence of displayed values and flags illegal glyphs, out-of-range digits and non-monotonic jumps.
- Sits beside the timer as an in-system checker, and as a bench scoreboard front-end.

Parameters:
- TIMER_LIMIT, 4, hour count at which the timer wraps to 00:00:00. Legal hours are 0..TIMER_LIMIT-1, TIMER_LIMIT ≤ 99.
- STABLE_CYC, 3, consecutive identical captured cycles required before a frame is accepted. Minimum 1.
- SECS_W, $clog2(TIMER_LIMIT*3600), width of total_secs.

Ports:
- sys_clk  in  1  system clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- digital_clock_in  in  [5:0][6:0]  segment vector per digit, bits {g,f,e,d,c,b,a}, active-high. Digit 0 = seconds units, 1 = seconds tens, 2/3 = minutes, 4/5 = hours.
- err_clear  in  1  synchronous clear of err_count.
- bcd_out  out  [5:0][3:0]  decoded digits of the last accepted frame.
- total_secs  out  SECS_W  hours*3600 + minutes*60 + seconds of the last accepted frame.
- synced  out  1  high once a baseline frame has been accepted.
- tick  out  1  one-cycle pulse: accepted frame equals previous + 1 s.
- wrap  out  1  one-cycle pulse: accepted frame is 00:00:00 and previous was TIMER_LIMIT*3600-1. Coincident with tick.
- zeroed  out  1  one-cycle pulse: accepted frame is 00:00:00 and the transition is not a wrap (clear/reset seen).
- jump_err  out  1  one-cycle pulse: any other change of accepted value.
- invalid_err  out  1  one-cycle pulse on entry into an invalid frame.
- err_count  out  8  saturating count of jump_err + invalid_err events.

Behaviour:
- Reset (async assert, sync release): all outputs 0, bcd_out all 0, state SYNC, stability counter 0.
- Stage 1 registers digital_clock_in.
- Stage 2 decodes per digit: 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9. Any other code is illegal.
- Frame is valid when all glyphs are legal, seconds tens ≤5, minutes tens ≤5 and hours (tens*10 + units) < TIMER_LIMIT.
- Stability filter: counter resets to 1 whenever the stage-1 vector differs from its previous value; otherwise it increments, saturating at STABLE_CYC. A frame is accepted on the cycle the counter reaches STABLE_CYC and the frame is valid. Each stable frame is accepted once.
- Latency: input held constant from cycle N gives acceptance and output update at cycle N+STABLE_CYC+1. total_secs updates in the same cycle as bcd_out.
- Invalid stable frame: invalid_err pulses once when the counter reaches STABLE_CYC. Outputs hold their last accepted values; state is unchanged.
- SYNC state: the first accepted frame loads outputs and sets synced. No tick/wrap/zeroed/jump_err pulse. Go to TRACK.
- TRACK state, accepted value V versus previous P:
  - V = P: no pulse (re-acceptance after an invalid interlude).
  - V = P+1: tick.
  - P = TIMER_LIMIT*3600-1 and V = 0: tick and wrap.
  - V = 0 otherwise: zeroed.
  - Anything else: jump_err.
- Pause (display static): no pulses.
- err_count increments by 1 per jump_err or invalid_err cycle (they cannot coincide) and saturates at 255.
- err_clear has priority: it zeroes err_count in the same cycle, discarding any simultaneous increment.
- Reset mid-frame discards the partial stability count and returns to SYNC.

Test Plan:
- Reset, hold 00:00:00 (all digits 0x3F) with STABLE_CYC=3 → synced=1 at cycle 4 after the input is stable, total_secs=0, no tick.
- Step seconds units 0x3F→0x06 after sync → tick one cycle, bcd_out[0]=1, total_secs=1, err_count=0.
- Present 03:59:59 then 00:00:00 (TIMER_LIMIT=4) → tick=1 and wrap=1 same cycle, total_secs=0. Present 00:12:05 then 00:00:00 → zeroed=1, no jump_err.
- Change digit 0 for 2 cycles only, then restore → no acceptance, no pulses. Sustain 00:00:05 after 00:00:01 → jump_err=1, err_count=1.
- Drive digit 1 = 0x7D (6) or digit 0 = 0x00 → invalid_err once, outputs hold. Restoring the previous frame → no pulse.
- Force 300 errors → err_count=255. Assert err_clear together with a jump_err → err_count=0. Assert rst_b low mid-sequence → all outputs 0, synced=0.

Source files
------------

// File: rtl/timer_display_monitor.sv
// Purpose: decodes a six-digit seven-segment timer bus back to BCD and seconds,
//          and flags illegal glyphs, out-of-range digits and non-monotonic steps.
// Latency: a frame held from capture edge k is accepted at edge k+STABLE_CYC+1.
//          The module never stalls. err_count saturates at 255.
// Ports:   sys_clk/rst_b clock and async active-low reset; digital_clock_in six
//          7-bit glyphs {g..a}, digit 0 = seconds units; err_clear clears
//          err_count; bcd_out/total_secs are the last accepted frame; synced,
//          tick, wrap, zeroed, jump_err and invalid_err are the status outputs.
module timer_display_monitor #(
  parameter int TIMER_LIMIT = 4,
  parameter int STABLE_CYC  = 3,
  parameter int SECS_W      = $clog2(TIMER_LIMIT * 3600)
) (
  input  logic                  sys_clk,
  input  logic                  rst_b,
  input  logic [5:0][6:0]       digital_clock_in,
  input  logic                  err_clear,
  output logic [5:0][3:0]       bcd_out,
  output logic [SECS_W-1:0]     total_secs,
  output logic                  synced,
  output logic                  tick,
  output logic                  wrap,
  output logic                  zeroed,
  output logic                  jump_err,
  output logic                  invalid_err,
  output logic [7:0]            err_count
);

  localparam int CNT_W    = $clog2(STABLE_CYC + 1);
  localparam int MAX_SECS = TIMER_LIMIT * 3600;

  typedef enum logic {SYNC, TRACK} state_t;

  state_t             state;
  logic [5:0][6:0]    seg_q;     // stage 1 capture
  logic [5:0][6:0]    seg_d;     // previous stage-1 value; the frame being judged
  logic [CNT_W-1:0]   cnt;
  logic               done;      // current stable frame already judged

  logic [5:0][3:0]    dig;
  logic [4:0]         dec;
  logic               legal_all;
  logic               frame_ok;
  logic               differ;
  logic               fresh;
  logic               ev_err;
  logic               is_same, is_next, is_wrap, is_zero;
  int                 hours, minutes, seconds, v_int, p_int;

  // Returns {legal, digit}.
  function automatic logic [4:0] decode_glyph(input logic [6:0] s);
    case (s)
      7'h3F:   return {1'b1, 4'd0};
      7'h06:   return {1'b1, 4'd1};
      7'h5B:   return {1'b1, 4'd2};
      7'h4F:   return {1'b1, 4'd3};
      7'h66:   return {1'b1, 4'd4};
      7'h6D:   return {1'b1, 4'd5};
      7'h7D:   return {1'b1, 4'd6};
      7'h07:   return {1'b1, 4'd7};
      7'h7F:   return {1'b1, 4'd8};
      7'h6F:   return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  always_comb begin
    dig       = '0;
    dec       = '0;
    legal_all = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dec       = decode_glyph(seg_d[i]);
      dig[i]    = dec[3:0];
      legal_all = legal_all & dec[4];
    end
    hours    = int'(dig[5]) * 10 + int'(dig[4]);
    minutes  = int'(dig[3]) * 10 + int'(dig[2]);
    seconds  = int'(dig[1]) * 10 + int'(dig[0]);
    frame_ok = legal_all && (dig[1] <= 4'd5) && (dig[3] <= 4'd5) && (hours < TIMER_LIMIT);
    v_int    = hours * 3600 + minutes * 60 + seconds;
    p_int    = int'(total_secs);
    is_same  = (v_int == p_int);
    is_next  = (v_int == p_int + 1);
    is_wrap  = (p_int == MAX_SECS - 1) && (v_int == 0);
    is_zero  = (v_int == 0);
    differ   = (seg_q != seg_d);
    // seg_d has now matched its predecessor STABLE_CYC times; judge it once.
    fresh    = (cnt == CNT_W'(STABLE_CYC)) && !done;
    ev_err   = fresh && (!frame_ok ||
               (state == TRACK && !is_same && !is_next && !is_wrap && !is_zero));
  end

  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= SYNC;
      seg_q       <= '0;
      seg_d       <= '0;
      cnt         <= '0;
      // Nothing is judged until the captured vector first changes, so the
      // reset contents of the capture registers are never mistaken for a frame.
      done        <= 1'b1;
      bcd_out     <= '0;
      total_secs  <= '0;
      synced      <= 1'b0;
      tick        <= 1'b0;
      wrap        <= 1'b0;
      zeroed      <= 1'b0;
      jump_err    <= 1'b0;
      invalid_err <= 1'b0;
      err_count   <= '0;
    end else begin
      seg_q <= digital_clock_in;
      seg_d <= seg_q;

      if (differ)
        cnt <= CNT_W'(1);
      else if (cnt != CNT_W'(STABLE_CYC))
        cnt <= cnt + CNT_W'(1);

      if (differ)
        done <= 1'b0;
      else if (fresh)
        done <= 1'b1;

      tick        <= 1'b0;
      wrap        <= 1'b0;
      zeroed      <= 1'b0;
      jump_err    <= 1'b0;
      invalid_err <= 1'b0;

      if (fresh) begin
        if (!frame_ok) begin
          invalid_err <= 1'b1;
        end else begin
          bcd_out    <= dig;
          total_secs <= SECS_W'(v_int);
          case (state)
            SYNC: begin
              state  <= TRACK;
              synced <= 1'b1;
            end
            TRACK: begin
              if (is_same) begin
                // re-acceptance of the same value: silent
              end else if (is_next) begin
                tick <= 1'b1;
              end else if (is_wrap) begin
                tick <= 1'b1;
                wrap <= 1'b1;
              end else if (is_zero) begin
                zeroed <= 1'b1;
              end else begin
                jump_err <= 1'b1;
              end
            end
            default: state <= SYNC;
          endcase
        end
      end

      if (err_clear)
        err_count <= '0;
      else if (ev_err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule
